// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit port.
package uart_pkg;

    // Transmitter line state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bit positions in the 2-bit CPU status port
    localparam int STATUS_FULL_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;

    // Start + 8 data + stop
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_tx_port_fifo_sc.sv
// Single-clock synchronous FIFO with show-ahead head (dout is the oldest entry).
// A pop in the same cycle as a push frees a slot first, so a full FIFO still
// accepts a push when it is also being popped.
module fifo_sc #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    // Storage array: no reset needed, validity is tracked by the count
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// CPU output-port UART transmitter: byte FIFO feeding an 8N1 serialiser,
// with registered full/busy status and a sticky overflow flag.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 16,
    parameter  int FIFO_DEPTH   = 4,
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT),
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [1:0] status,
    output logic       ovf,
    output logic       tx
);

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic [1:0]        r_status;
    logic              r_ovf;

    logic [7:0]        w_dout;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_bit_end;
    logic              w_pop;
    logic              w_accept;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_fsm_busy_nxt;

    fifo_sc #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // Head is taken when idle, or at the last stop cycle for a gapless handoff
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    // Mirrors the FIFO's accept rule so status/ovf can be registered alongside it
    assign w_accept  = wr_en && (!w_full || w_pop);
    assign w_cnt_nxt = w_count + CW'(w_accept) - CW'(w_pop);

    // FSM is non-idle after this edge unless it is idle with nothing to pop,
    // or it finishes STOP with nothing to pop
    assign w_fsm_busy_nxt = (r_state == IDLE) ? !w_empty
                          : !((r_state == STOP) && w_bit_end && w_empty);

    // Serialiser FSM: baud counter, bit counter, shift register and line driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_dout;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'(DATA_BITS - 1)) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_dout;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Status and overflow registered from next-state values so they track each edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= 2'b00;
            r_ovf    <= 1'b0;
        end else begin
            r_status[STATUS_FULL_BIT] <= (w_cnt_nxt == CW'(FIFO_DEPTH));
            r_status[STATUS_BUSY_BIT] <= (w_cnt_nxt != '0) || w_fsm_busy_nxt;
            if (wr_en && !w_accept) r_ovf <= 1'b1;
        end
    end

    assign tx     = r_tx;
    assign status = r_status;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_port;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] status;
    logic       ovf;
    logic       tx;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .status  (status),
        .ovf     (ovf),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks tx over frame cycles [from..last]; cycle 0 is the first start-bit cycle.
    // Caller is positioned on the falling edge just before cycle 'from'.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int from, input int last);
        logic exp_bit;
        int   bi;
        for (int i = from; i <= last; i++) begin
            @(negedge clk);
            bi = i / CPB;
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = b[bi-1];
            chk($sformatf("%s_c%0d", tag, i), 32'(tx), 32'(exp_bit));
        end
    endtask

    // Counts cycles where the line is not idle-high or status not 00
    task automatic quiet(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || status !== 2'b00) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle line
        quiet("idle_1000", 1000);

        // Single byte A5
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        chk("a5_busy_k", 32'(status), 32'b01);
        chk("a5_tx_k", 32'(tx), 32'd1);
        expect_frame("a5", 8'hA5, 0, 39);
        chk("a5_busy_last", 32'(status), 32'b01);
        @(negedge clk);
        chk("a5_status_end", 32'(status), 32'b00);
        chk("a5_tx_end", 32'(tx), 32'd1);

        // Back-to-back 00 then FF
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
        @(negedge clk); wr_data = 8'hFF;
        @(negedge clk); wr_en = 1'b0;
        chk("b2b_tx0", 32'(tx), 32'd0);
        expect_frame("b2b0", 8'h00, 1, 39);
        expect_frame("b2b1", 8'hFF, 0, 39);
        @(negedge clk);
        chk("b2b_status_end", 32'(status), 32'b00);

        // Fill and overflow
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_data = 8'h33;
        chk("fill_tx_start", 32'(tx), 32'd0);
        @(negedge clk); wr_data = 8'h44;
        @(negedge clk); wr_data = 8'h55;
        @(negedge clk);
        chk("fill_full", 32'(status), 32'b11);
        chk("fill_ovf0", 32'(ovf), 32'd0);
        wr_data = 8'h66;
        @(negedge clk); wr_en = 1'b0;
        chk("fill_ovf1", 32'(ovf), 32'd1);
        chk("fill_full2", 32'(status), 32'b11);
        expect_frame("f11", 8'h11, 5, 39);
        expect_frame("f22", 8'h22, 0, 39);
        expect_frame("f33", 8'h33, 0, 39);
        expect_frame("f44", 8'h44, 0, 39);
        expect_frame("f55", 8'h55, 0, 39);
        chk("fill_ovf_sticky", 32'(ovf), 32'd1);
        quiet("fill_no_66", 50);

        // Reset mid-frame during data bit 3, with a byte still buffered
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_en = 1'b0;
        expect_frame("mid", 8'h5A, 1, 17);
        chk("mid_tx_bit3", 32'(tx), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_status", 32'(status), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        quiet("mid_no_activity", 100);

        // Simultaneous pop and write while full
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA1;
        @(negedge clk); wr_data = 8'hB2;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_data = 8'hD4;
        @(negedge clk); wr_data = 8'hE5;
        @(negedge clk); wr_en = 1'b0;
        chk("sim_full", 32'(status), 32'b11);
        expect_frame("sA1", 8'hA1, 4, 39);
        chk("sim_full_pre", 32'(status), 32'b11);
        wr_en = 1'b1; wr_data = 8'hF6;
        expect_frame("sB2", 8'hB2, 0, 0);
        wr_en = 1'b0;
        chk("sim_status", 32'(status), 32'b11);
        chk("sim_ovf", 32'(ovf), 32'd0);
        expect_frame("sB2", 8'hB2, 1, 39);
        expect_frame("sC3", 8'hC3, 0, 39);
        expect_frame("sD4", 8'hD4, 0, 39);
        expect_frame("sE5", 8'hE5, 0, 39);
        expect_frame("sF6", 8'hF6, 0, 39);
        @(negedge clk);
        chk("sim_status_end", 32'(status), 32'b00);
        chk("sim_ovf_end", 32'(ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
